// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states,
// default timeout and the access legality/alignment check.
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam int DEFAULT_TIMEOUT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } lsu_state_e;

   // True when the width code is legal for the direction and the address is naturally aligned.
   function automatic logic access_ok(input logic isStore, input logic [2:0] f3,
                                      input logic [1:0] addrLo);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_LB:   ok = 1'b1;
         F3_LH:   ok = ~addrLo[0];
         F3_LW:   ok = (addrLo == 2'b00);
         F3_LBU:  ok = ~isStore;
         F3_LHU:  ok = ~isStore & ~addrLo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and data replication,
// load lane extraction with sign or zero extension.
module lsu_align (
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] mem_rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        signedLoad;

   always_comb begin
      byteSel    = mem_rdata_i[7:0];
      halfSel    = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      signedLoad = ~funct3_i[2];
      case (addr_lo_i)
         2'd0:    byteSel = mem_rdata_i[7:0];
         2'd1:    byteSel = mem_rdata_i[15:8];
         2'd2:    byteSel = mem_rdata_i[23:16];
         default: byteSel = mem_rdata_i[31:24];
      endcase
   end

   // funct3[1:0] is the access size; funct3[2] selects zero extension on loads.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      rdata_o = mem_rdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signedLoad & byteSel[7]}}, byteSel};
         end
         2'b01: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{signedLoad & halfSel[15]}}, halfSel};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = mem_rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store unit: accepts one access in IDLE, drives a
// held memory request until ack or timeout, then pulses done (with err on failure).
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

   lsu_state_e        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              store_q, store_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   logic [3:0]        alignBe;
   logic [31:0]       alignWdata;
   logic [31:0]       alignRdata;

   lsu_align uAlign (
      .funct3_i    (f3_q),
      .addr_lo_i   (addr_q[1:0]),
      .wdata_i     (wdata_q),
      .mem_rdata_i (mem_rdata),
      .be_o        (alignBe),
      .wdata_o     (alignWdata),
      .rdata_o     (alignRdata)
   );

   // Rejected accesses never touch the latched request, so mem_* stay as last driven.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      store_d = store_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (access_ok(is_store, funct3, addr[1:0])) begin
                  state_d = ST_REQ;
                  cnt_d   = '0;
                  store_d = is_store;
                  f3_d    = funct3;
                  addr_d  = addr;
                  wdata_d = wdata;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               state_d = ST_DONE;
               if (!store_q) begin
                  rdata_d = alignRdata;
               end
            end else if (cnt_q == CntLast) begin
               state_d = ST_ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         store_q <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) || (state_q == ST_ERR);
   assign err       = (state_q == ST_ERR);
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == ST_REQ);
   assign mem_we    = (state_q == ST_REQ) & store_q;
   assign mem_be    = (state_q == ST_REQ) ? alignBe : 4'b0000;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = alignWdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed literal cases plus random accesses checked
// every cycle against a transaction timeline model built from the access rules.
module tb_load_store_unit;

   localparam int T = 3;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        err;
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] reqAddr;
      logic [31:0] reqWdata;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          busyEnd = 0;
   int          lastStart = 0;
   bit          modelOn = 0;
   logic [31:0] expRdata = '0;
   exp_t        expTab[int];
   logic [31:0] rdataAt[int];
   logic [31:0] ackAt[int];

   load_store_unit #(.ADDR_W(32), .TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory side: ack and read data come from the schedule the model wrote.
   always @(negedge clk) begin
      if (ackAt.exists(cyc)) begin
         mem_ack   = 1'b1;
         mem_rdata = ackAt[cyc];
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic bit modelOk(input bit st, input bit [2:0] f3, input bit [31:0] a);
      bit legal;
      int sz;
      legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      sz    = 1 << f3[1:0];
      return legal && ((int'(a[1:0]) % sz) == 0);
   endfunction

   function automatic logic [3:0] modelBe(input bit [2:0] f3, input bit [31:0] a);
      int off;
      off = int'(a[1:0]);
      if (f3[1:0] == 2'd0) return 4'(1 << off);
      if (f3[1:0] == 2'd1) return 4'(3 << (off & 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] modelLane(input bit [2:0] f3, input bit [31:0] wd);
      if (f3[1:0] == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] modelLoad(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
      bit [31:0] v;
      if (f3[1:0] == 2'd0) begin
         v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
         if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else if (f3[1:0] == 2'd1) begin
         v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Drives one request, writes its expected timeline, returns in its acceptance cycle.
   task automatic applyStimulus(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, input bit [31:0] rd, input int w,
                                input bit lateAck);
      int   c, s, d, nreq;
      exp_t e;
      @(negedge clk);
      start    = 1'b1;
      is_store = st;
      funct3   = f3;
      addr     = a;
      wdata    = wd;
      c = cyc;
      s = (c > busyEnd) ? c : busyEnd + 1;
      if (!modelOk(st, f3, a)) begin
         d = s + 1;
      end else begin
         nreq = (w < T) ? w + 1 : T;
         for (int k = 1; k <= nreq; k++) begin
            e          = '0;
            e.busy     = 1'b1;
            e.req      = 1'b1;
            e.we       = st;
            e.be       = modelBe(f3, a);
            e.reqAddr  = a & 32'hFFFF_FFFC;
            e.reqWdata = modelLane(f3, wd);
            expTab[s + k] = e;
         end
         d = s + nreq + 1;
         if (w < T) begin
            ackAt[s + 1 + w] = rd;
            if (!st) rdataAt[d] = modelLoad(f3, a, rd);
         end
      end
      e      = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      e.err  = !modelOk(st, f3, a) || (w >= T);
      expTab[d] = e;
      if (lateAck && !ackAt.exists(d)) ackAt[d] = $urandom;
      busyEnd   = d;
      lastStart = s;
      while (cyc < s) @(negedge clk);
   endtask

   task automatic nextCycle();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
      checkOutput({tag, "_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
      checkOutput({tag, "_be"}, 32'(mem_be), 32'd0);
      checkOutput({tag, "_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_rdata"}, rdata, 32'd0);
   endtask

   // Per-cycle comparison of every DUT output against the model timeline.
   always @(negedge clk) begin : cmpProc
      exp_t e;
      if (modelOn) begin
         e = expTab.exists(cyc) ? expTab[cyc] : '0;
         if (rdataAt.exists(cyc)) expRdata = rdataAt[cyc];
         checkOutput("busy", 32'(busy), 32'(e.busy));
         checkOutput("done", 32'(done), 32'(e.done));
         checkOutput("err", 32'(err), 32'(e.err));
         checkOutput("mem_req", 32'(mem_req), 32'(e.req));
         checkOutput("mem_we", 32'(mem_we), 32'(e.we));
         checkOutput("mem_be", 32'(mem_be), 32'(e.be));
         checkOutput("rdata", rdata, expRdata);
         if (e.req) begin
            checkOutput("mem_addr", mem_addr, e.reqAddr);
            checkOutput("mem_wdata", mem_wdata, e.reqWdata);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog cycle %0d got no finish expected finish", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit        st;
      bit [2:0]  f3;
      bit [31:0] a;
      int        s;
      rst      = 1'b1;
      start    = 1'b0;
      is_store = 1'b0;
      funct3   = '0;
      addr     = '0;
      wdata    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkAllZero("reset");
      busyEnd  = cyc;
      expRdata = '0;
      modelOn  = 1'b1;

      applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
      nextCycle();
      checkOutput("sw_req", 32'(mem_req), 32'd1);
      checkOutput("sw_addr", mem_addr, 32'h10);
      checkOutput("sw_be", 32'(mem_be), 32'hF);
      checkOutput("sw_we", 32'(mem_we), 32'd1);
      checkOutput("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      nextCycle();
      checkOutput("sw_done", 32'(done), 32'd1);
      checkOutput("sw_err", 32'(err), 32'd0);

      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_FF00, 0, 1'b0);
      nextCycle();
      nextCycle();
      checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);
      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_FF00, 0, 1'b0);
      nextCycle();
      nextCycle();
      checkOutput("lbu_rdata", rdata, 32'h0000_0080);

      applyStimulus(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'h0, 1, 1'b0);
      nextCycle();
      checkOutput("sh_addr", mem_addr, 32'h20);
      checkOutput("sh_be", 32'(mem_be), 32'hC);
      checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      nextCycle();
      checkOutput("sh_hold_addr", mem_addr, 32'h20);
      checkOutput("sh_hold_be", 32'(mem_be), 32'hC);
      nextCycle();
      checkOutput("sh_done", 32'(done), 32'd1);

      applyStimulus(1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 0, 1'b0);
      nextCycle();
      checkOutput("mis_req", 32'(mem_req), 32'd0);
      checkOutput("mis_done", 32'(done), 32'd1);
      checkOutput("mis_err", 32'(err), 32'd1);
      checkOutput("mis_rdata", rdata, 32'h0000_0080);
      applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 1'b0);
      nextCycle();
      checkOutput("ill_req", 32'(mem_req), 32'd0);
      checkOutput("ill_done", 32'(done), 32'd1);
      checkOutput("ill_err", 32'(err), 32'd1);

      applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 9, 1'b0);
      for (int k = 0; k < T; k++) begin
         nextCycle();
         checkOutput("to_req", 32'(mem_req), 32'd1);
      end
      nextCycle();
      checkOutput("to_done", 32'(done), 32'd1);
      checkOutput("to_err", 32'(err), 32'd1);
      checkOutput("to_req_drop", 32'(mem_req), 32'd0);
      nextCycle();
      checkOutput("to_idle", 32'(busy), 32'd0);

      applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 9, 1'b0);
      s = lastStart;
      ackAt[s + 1] = 32'h1234_5678;
      ackAt[s + 2] = 32'h8765_4321;
      nextCycle();
      checkOutput("rst_pre_req", 32'(mem_req), 32'd1);
      modelOn = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkAllZero("rst_mid");
      @(negedge clk);
      checkOutput("rst_ack_busy", 32'(busy), 32'd0);
      checkOutput("rst_ack_done", 32'(done), 32'd0);
      checkOutput("rst_ack_rdata", rdata, 32'd0);
      expTab.delete();
      rdataAt.delete();
      expRdata = '0;
      busyEnd  = cyc;
      modelOn  = 1'b1;

      for (int i = 0; i < 300; i++) begin
         st = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) begin
            f3 = 3'($urandom_range(0, 7));
         end else if (st) begin
            f3 = 3'($urandom_range(0, 2));
         end else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         applyStimulus(st, f3, a, $urandom, $urandom, $urandom_range(0, 4),
                       1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               start    = 1'b0;
               is_store = 1'($urandom_range(0, 1));
               funct3   = 3'($urandom_range(0, 7));
               addr     = $urandom;
               wdata    = $urandom;
            end
         end
      end
      nextCycle();
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32: width of the CPU address and memory address.
REQ-002 Parameter TIMEOUT, default 255: maximum number of REQ cycles without mem_ack before the access is aborted; legal range 1..65535.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  access request, sampled only in IDLE.
REQ-006 is_store  in  1  1 = store, 0 = load; sampled with start.
REQ-007 funct3  in  3  RV32 width/sign code; sampled with start.
REQ-008 addr  in  ADDR_W  byte address (ALU result); sampled with start.
REQ-009 wdata  in  32  store data (rs2); sampled with start.
REQ-010 busy  out  1  stall to CPU; high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  qualifies done; 1 = misaligned, illegal funct3 or timeout.
REQ-013 rdata  out  32  load result after extension; holds its value until the next successful load.
REQ-014 mem_req, mem_we  out  1 each  memory request; write enable.
REQ-015 mem_addr  out  ADDR_W  word address with bits [1:0] forced to 0.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  lane-aligned store data.
REQ-018 mem_rdata  in  32  word read data, valid when mem_ack is high.
REQ-019 mem_ack  in  1  memory completion, one cycle, valid only while mem_req is high.

Function
REQ-020 FSM states: IDLE, REQ, DONE, ERR.
REQ-021 In IDLE, start with a legal and aligned access SHALL latch is_store, funct3, addr and wdata, clear the timeout counter, and move to REQ.
REQ-022 Legal funct3 codes: loads 000, 001, 010, 100, 101; stores 000, 001, 010; every other code is illegal.
REQ-023 Misalignment rules: a halfword access with addr[0]=1 is misaligned; a word access with addr[1:0]!=0 is misaligned.
REQ-024 In IDLE, start with an illegal funct3 or a misaligned address SHALL move to ERR without asserting mem_req.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 In REQ, mem_req=1 and all mem_* outputs are driven from latched values and stay stable until mem_ack.
REQ-027 In REQ, mem_ack=1 moves the FSM to DONE; on a load, extended read data is captured into rdata on the same edge.
REQ-028 In REQ without mem_ack, the counter increments; when it reaches TIMEOUT the FSM moves to ERR and mem_req drops.
REQ-029 A late mem_ack arriving outside REQ SHALL be ignored.
REQ-030 DONE: done=1, err=0 for one cycle, then the FSM returns to IDLE.
REQ-031 ERR: done=1, err=1 for one cycle, then the FSM returns to IDLE; rdata is unchanged.
REQ-032 Latency: if mem_ack arrives in the first REQ cycle, done is asserted 2 cycles after start; each wait cycle adds 1.
REQ-033 Store lane mapping:
- SB: mem_be = 1<<addr[1:0], byte replicated on all 4 lanes.
- SH: mem_be = addr[1] ? 1100 : 0011, halfword replicated on both halves.
- SW: mem_be = 1111, data passed through unchanged.
REQ-034 Load extraction:
- Byte loads select lane addr[1:0].
- Halfword loads select the half given by addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-035 During loads mem_we=0 and mem_be is driven as for a store of the same width.
REQ-036 Outside REQ: mem_req=0, mem_we=0, mem_be=0.

Reset
REQ-037 rst SHALL force the following on the next edge, including mid-access:
- state = IDLE, counter = 0.
- rdata, busy, done, err, mem_req, mem_we, mem_be, mem_addr and mem_wdata all 0.
REQ-038 A mem_ack arriving in the reset cycle or the cycle after it SHALL have no effect.

Structure
REQ-039 The shared package SHALL hold:
- the funct3 width codes (LB, LH, LW, LBU, LHU);
- the FSM state encoding;
- the default TIMEOUT.
REQ-040 One combinational sub-module, lsu_align, SHALL implement store lane mapping/byte enables and load extraction/extension; the top level SHALL hold the FSM, counter and registers.

Verification
REQ-041 SW addr=0x10, wdata=0xDEADBEEF, ack in the first REQ cycle -> mem_addr=0x10, be=1111, we=1, done at start+2, err=0.
REQ-042 LB addr=0x13, mem_rdata=0x80FF_FF00 -> rdata=0xFFFFFF80; LBU at the same address -> rdata=0x00000080.
REQ-043 SH addr=0x22, wdata=0x0000ABCD -> mem_addr=0x20, be=1100, mem_wdata=0xABCDABCD.
REQ-044 LW addr=0x05 -> no mem_req, done=1 and err=1 at start+1, rdata unchanged; funct3=011 -> same response.
REQ-045 Timeout and reset:
- TIMEOUT=3, no ack -> mem_req high for 3 cycles, then err pulse, then IDLE.
- rst asserted in REQ -> IDLE with all outputs 0 on the next edge; an ack one cycle later is ignored.
REQ-046 start held high through busy -> exactly one access per start accepted in IDLE; back-to-back accesses complete in order.
